// File: rtl/dcache_pkg.sv
// Shared D-cache constants and the flush FSM state encoding, used by the cache and its flush unit.
package dcache_pkg;
  localparam int DC_SETS   = 32;
  localparam int DC_SET_W  = $clog2(DC_SETS);
  localparam int DC_ADDR_W = 64;
  localparam int DC_TAG_W  = DC_ADDR_W - DC_SET_W - 2;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_SCAN,
    FL_WRITE,
    FL_DONE
  } flush_state_e;
endpackage

// File: rtl/dcache_flush_walker.sv
// Set/way cursor for the flush walk: way 0 then way 1 within a set, then the next set.
module dcache_flush_walker
  import dcache_pkg::*;
#(
  parameter int SETS = DC_SETS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    advance,
  output logic [$clog2(SETS)-1:0] set_idx,
  output logic                    way,
  output logic                    last
);
  localparam int SET_W = $clog2(SETS);

  logic [SET_W-1:0] set_q, set_d;
  logic             way_q, way_d;

  always_comb begin
    set_d = set_q;
    way_d = way_q;
    if (start) begin
      set_d = '0;
      way_d = 1'b0;
    end else if (advance) begin
      way_d = ~way_q;
      if (way_q) set_d = set_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q <= '0;
      way_q <= 1'b0;
    end else begin
      set_q <= set_d;
      way_q <= way_d;
    end
  end

  // SETS is a power of two, so the final line is all-ones set with way 1.
  assign last    = (&set_q) & way_q;
  assign set_idx = set_q;
  assign way     = way_q;
endmodule

// File: rtl/dcache_flush_unit.sv
// Write-back drain engine: walks every set/way, writes valid+dirty words to memory, clears dirty bits.
// Optional DCACHE_FLUSH_INV_EN adds inv_clr so the flush also invalidates every valid line.
module dcache_flush_unit
  import dcache_pkg::*;
#(
  parameter int SETS   = DC_SETS,
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_req,
  output logic                                flush_busy,
  output logic                                flush_done,
  output logic [$clog2(SETS)-1:0]             cache_set,
  output logic                                cache_way,
  input  logic                                line_valid,
  input  logic                                line_dirty,
  input  logic [ADDR_W-$clog2(SETS)-3:0]      line_tag,
  input  logic [DATA_W-1:0]                   line_data,
  output logic                                dirty_clr,
  output logic [$clog2(SETS)-1:0]             clr_set,
  output logic                                clr_way,
`ifdef DCACHE_FLUSH_INV_EN
  output logic                                inv_clr,
`endif
  output logic                                mem_req,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_wdata,
  input  logic                                mem_ready
);
  localparam int SET_W = $clog2(SETS);

  flush_state_e      state_q, state_d;
  logic              walk_start, walk_adv, walk_last;
  logic              load_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SET_W-1:0]  clr_set_q;
  logic              clr_way_q;
  logic              dirty_clr_q, dirty_clr_d;
`ifdef DCACHE_FLUSH_INV_EN
  logic              inv_clr_q, inv_clr_d;
`endif

  dcache_flush_walker #(.SETS(SETS)) u_walker (
    .clk     (clk),
    .rst     (rst),
    .start   (walk_start),
    .advance (walk_adv),
    .set_idx (cache_set),
    .way     (cache_way),
    .last    (walk_last)
  );

  always_comb begin
    state_d     = state_q;
    walk_start  = 1'b0;
    walk_adv    = 1'b0;
    load_wr     = 1'b0;
    dirty_clr_d = 1'b0;
`ifdef DCACHE_FLUSH_INV_EN
    inv_clr_d   = 1'b0;
`endif
    unique case (state_q)
      FL_IDLE: begin
        if (flush_req) begin
          walk_start = 1'b1;
          state_d    = FL_SCAN;
        end
      end
      FL_SCAN: begin
        if (line_valid && line_dirty) begin
          load_wr = 1'b1;
          state_d = FL_WRITE;
        end else begin
`ifdef DCACHE_FLUSH_INV_EN
          inv_clr_d = line_valid;
`endif
          walk_adv = 1'b1;
          if (walk_last) state_d = FL_DONE;
        end
      end
      FL_WRITE: begin
        // The walker still points at the written line, so last is valid here.
        if (mem_ready) begin
          dirty_clr_d = 1'b1;
`ifdef DCACHE_FLUSH_INV_EN
          inv_clr_d   = 1'b1;
`endif
          walk_adv    = 1'b1;
          state_d     = walk_last ? FL_DONE : FL_SCAN;
        end
      end
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FL_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      clr_set_q   <= '0;
      clr_way_q   <= 1'b0;
      dirty_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dirty_clr_q <= dirty_clr_d;
      if (load_wr) begin
        addr_q  <= {line_tag, cache_set, 2'b00};
        wdata_q <= line_data;
      end
      // Capture the examined line; the clear pulse always lands one cycle later.
      if (state_q == FL_SCAN) begin
        clr_set_q <= cache_set;
        clr_way_q <= cache_way;
      end
    end
  end

`ifdef DCACHE_FLUSH_INV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_clr_q <= 1'b0;
    else     inv_clr_q <= inv_clr_d;
  end
  assign inv_clr = inv_clr_q;
`endif

  assign flush_busy = (state_q != FL_IDLE);
  assign flush_done = (state_q == FL_DONE);
  assign mem_req    = (state_q == FL_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign dirty_clr  = dirty_clr_q;
  assign clr_set    = clr_set_q;
  assign clr_way    = clr_way_q;
endmodule
